// File: rtl/sub_mean.sv
// sub_mean: per-window DC removal.
// Collects 64-sample windows of signed PCM into a ping-pong buffer and sums them.
// When a window completes, its mean is taken with an arithmetic shift (floor).
// The same window is then replayed with the mean subtracted and the result saturated.
//
// state    | meaning
// ST_IDLE  | no window waiting to be replayed
// ST_DRAIN | reading the last completed bank, one sample per cycle
module sub_mean #(
    parameter int DATA_WIDTH  = 16,
    parameter int WINDOW_LOG2 = 6
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic signed [DATA_WIDTH-1:0] i_data,
    input  logic                         i_valid,
    output logic signed [DATA_WIDTH-1:0] o_data,
    output logic                         o_valid,
    output logic                         o_last,
    output logic signed [DATA_WIDTH-1:0] o_mean,
    output logic                         o_mean_valid
);

    localparam int WIN   = 1 << WINDOW_LOG2;
    localparam int ACC_W = DATA_WIDTH + WINDOW_LOG2;
    localparam logic [WINDOW_LOG2-1:0] PTR_LAST = {WINDOW_LOG2{1'b1}};
    localparam logic [DATA_WIDTH-1:0]  SAT_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0]  SAT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic {ST_IDLE, ST_DRAIN} state_t;

    logic [DATA_WIDTH-1:0]         r_mem [0:2*WIN-1];
    logic [WINDOW_LOG2-1:0]        r_wr_ptr;
    logic [WINDOW_LOG2-1:0]        r_rd_ptr;
    logic                          r_wr_bank;
    logic                          r_rd_bank;
    logic signed [ACC_W-1:0]       r_acc;
    state_t                        r_state;
    logic signed [DATA_WIDTH-1:0]  r_rd_data;
    logic signed [DATA_WIDTH-1:0]  r_rd_mean;
    logic                          r_rd_valid;
    logic                          r_rd_last;

    logic                          w_close;
    logic signed [ACC_W-1:0]       w_acc_next;
    logic signed [DATA_WIDTH-1:0]  w_mean_next;
    logic [DATA_WIDTH:0]           w_diff;
    logic [DATA_WIDTH-1:0]         w_sat;

    assign w_close     = i_valid && (r_wr_ptr == PTR_LAST);
    assign w_acc_next  = r_acc + ACC_W'(i_data);
    // Taking the upper bits of the full sum is the floor division by the window length.
    assign w_mean_next = w_acc_next[ACC_W-1:WINDOW_LOG2];

    // Sample storage; no reset so it maps onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (i_valid) begin
            r_mem[{r_wr_bank, r_wr_ptr}] <= i_data;
        end
    end

    // Fill path: accumulate, advance the write pointer, close the window and publish its mean.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr     <= '0;
            r_wr_bank    <= 1'b0;
            r_acc        <= '0;
            o_mean       <= '0;
            o_mean_valid <= 1'b0;
        end else begin
            o_mean_valid <= 1'b0;
            if (i_valid) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_close) begin
                    r_acc        <= '0;
                    r_wr_bank    <= ~r_wr_bank;
                    o_mean       <= w_mean_next;
                    o_mean_valid <= 1'b1;
                end else begin
                    r_acc <= w_acc_next;
                end
            end
        end
    end

    // Drain FSM: a window close always (re)starts a drain on the bank just filled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_rd_ptr   <= '0;
            r_rd_bank  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            r_rd_valid <= (r_state == ST_DRAIN);
            r_rd_last  <= (r_state == ST_DRAIN) && (r_rd_ptr == PTR_LAST);
            if (w_close) begin
                r_state   <= ST_DRAIN;
                r_rd_bank <= r_wr_bank;
                r_rd_ptr  <= '0;
            end else if (r_state == ST_DRAIN) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                if (r_rd_ptr == PTR_LAST) begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

    // Registered bank read. The mean travels with each sample, so the final read of a
    // window keeps the old mean even when the next window closes on the same edge.
    always_ff @(posedge i_clk) begin
        if (r_state == ST_DRAIN) begin
            r_rd_data <= r_mem[{r_rd_bank, r_rd_ptr}];
            r_rd_mean <= o_mean;
        end
    end

    // Subtract the mean one bit wider, then clip when the two top bits disagree.
    always_comb begin
        w_diff = {r_rd_data[DATA_WIDTH-1], r_rd_data} - {r_rd_mean[DATA_WIDTH-1], r_rd_mean};
        w_sat  = w_diff[DATA_WIDTH-1:0];
        if (w_diff[DATA_WIDTH] != w_diff[DATA_WIDTH-1]) begin
            w_sat = w_diff[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        end
    end

    // Output register stage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data  <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end else begin
            o_valid <= r_rd_valid;
            o_last  <= r_rd_valid && r_rd_last;
            if (r_rd_valid) begin
                o_data <= w_sat;
            end
        end
    end

endmodule
